// File: rtl/unified_mem_arbiter.sv
// Arbiter for the single-port unified I/D memory: IF vs MEM-stage D port.
// Define UNIFIED_MEM_ARB_PERF_EN to add the perf_* counter outputs.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int MEM_LAT    = 1,
  parameter int MAX_STREAK = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic [1:0]        d_re,
  input  logic [1:0]        d_we,
  input  logic              d_unsigned,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_read,
  output logic [1:0]        mem_write,
  output logic [31:0]       mem_wdata,
  output logic              mem_unsigned,
  output logic              mem_is_fetch,
  input  logic [31:0]       mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
`ifdef UNIFIED_MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_conflicts,
  output logic [31:0]       perf_if_wait,
  output logic [31:0]       perf_d_wait
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);
  localparam logic [3:0] ST_MAX = 4'(MAX_STREAK);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [3:0]        streak_q, streak_d;
  logic [ADDR_W-1:0] addr_q;
  logic              fetch_q, store_q;
  logic              if_rvalid_q, d_rvalid_q;
  logic [31:0]       if_rdata_q, d_rdata_q;
  logic              d_eff, if_win, grant;

  // A D request with no read or write size is not a request at all.
  assign d_eff  = d_req & ((|d_re) | (|d_we));
  assign if_win = if_req & (~d_eff | (streak_q == ST_MAX));
  assign grant  = reset & (state_q == IDLE) & (if_req | d_eff);
  assign if_gnt = grant & if_win;
  assign d_gnt  = grant & ~if_win;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          cnt_d   = LAT_M1;
          state_d = (MEM_LAT == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_addr     = addr_q;
    mem_is_fetch = fetch_q;
    mem_read     = 2'b00;
    mem_write    = 2'b00;
    mem_wdata    = '0;
    mem_unsigned = 1'b0;
    unique case (1'b1)
      if_gnt: begin
        mem_addr     = if_addr;
        mem_is_fetch = 1'b1;
        mem_read     = 2'b11;
      end
      d_gnt: begin
        mem_addr     = d_addr;
        mem_is_fetch = 1'b0;
        mem_read     = (|d_we) ? 2'b00 : d_re;
        mem_write    = d_we;
        mem_wdata    = d_wdata;
        mem_unsigned = d_unsigned;
      end
      default: ;
    endcase
  end

  always_comb begin
    streak_d = streak_q;
    if (!if_req || if_gnt)
      streak_d = '0;
    else if (d_gnt && streak_q != ST_MAX)
      streak_d = streak_q + 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      streak_q    <= '0;
      addr_q      <= '0;
      fetch_q     <= 1'b0;
      store_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      if_rvalid_q <= (state_q == RESP) & fetch_q;
      d_rvalid_q  <= (state_q == RESP) & ~fetch_q;
      if (grant) begin
        addr_q  <= mem_addr;
        fetch_q <= if_win;
        store_q <= ~if_win & (|d_we);
      end
      if (state_q == RESP) begin
        if (fetch_q)
          if_rdata_q <= mem_rdata;
        else if (!store_q)
          d_rdata_q <= mem_rdata;
      end
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  // Stalls are forced low while reset is asserted.
  assign stall_if  = reset & if_req & ~if_rvalid_q;
  assign stall_mem = reset & d_eff & ~d_rvalid_q;

`ifdef UNIFIED_MEM_ARB_PERF_EN
  logic [31:0] conf_q, ifw_q, dw_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conf_q <= '0;
      ifw_q  <= '0;
      dw_q   <= '0;
    end else begin
      conf_q <= conf_q + {31'b0, (state_q == IDLE) & if_req & d_eff};
      ifw_q  <= ifw_q + {31'b0, stall_if};
      dw_q   <= dw_q + {31'b0, stall_mem};
    end
  end

  assign perf_conflicts = conf_q;
  assign perf_if_wait   = ifw_q;
  assign perf_d_wait    = dw_q;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: instance 0 has MEM_LAT=1, instance 1 MEM_LAT=3.
// Directed scenarios plus a randomized run against a transaction-level model.
module tb_unified_mem_arbiter;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic          if_req    [2];
  logic [AW-1:0] if_addr   [2];
  logic          if_gnt    [2];
  logic          if_rvalid [2];
  logic [31:0]   if_rdata  [2];
  logic          d_req     [2];
  logic [1:0]    d_re      [2];
  logic [1:0]    d_we      [2];
  logic          d_uns     [2];
  logic [AW-1:0] d_addr    [2];
  logic [31:0]   d_wdata   [2];
  logic          d_gnt     [2];
  logic          d_rvalid  [2];
  logic [31:0]   d_rdata   [2];
  logic [AW-1:0] m_addr    [2];
  logic [1:0]    m_read    [2];
  logic [1:0]    m_write   [2];
  logic [31:0]   m_wdata   [2];
  logic          m_uns     [2];
  logic          m_fetch   [2];
  logic [31:0]   m_rdata   [2];
  logic          stall_if  [2];
  logic          stall_mem [2];
`ifdef UNIFIED_MEM_ARB_PERF_EN
  logic [31:0]   perf_c    [2];
  logic [31:0]   perf_iw   [2];
  logic [31:0]   perf_dw   [2];
`endif

  logic [31:0]   mem  [2][64];
  logic [31:0]   pipe [2][3];
  logic          pl_we;
  int            pl_k;
  logic [AW-1:0] pl_addr;
  logic [31:0]   pl_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    unified_mem_arbiter #(
      .ADDR_W(AW), .MEM_LAT(k == 0 ? 1 : 3), .MAX_STREAK(3)
    ) u_dut (
      .clk(clk), .reset(rst_n),
      .if_req(if_req[k]), .if_addr(if_addr[k]), .if_gnt(if_gnt[k]),
      .if_rvalid(if_rvalid[k]), .if_rdata(if_rdata[k]),
      .d_req(d_req[k]), .d_re(d_re[k]), .d_we(d_we[k]),
      .d_unsigned(d_uns[k]), .d_addr(d_addr[k]), .d_wdata(d_wdata[k]),
      .d_gnt(d_gnt[k]), .d_rvalid(d_rvalid[k]), .d_rdata(d_rdata[k]),
      .mem_addr(m_addr[k]), .mem_read(m_read[k]), .mem_write(m_write[k]),
      .mem_wdata(m_wdata[k]), .mem_unsigned(m_uns[k]),
      .mem_is_fetch(m_fetch[k]), .mem_rdata(m_rdata[k]),
      .stall_if(stall_if[k]), .stall_mem(stall_mem[k])
`ifdef UNIFIED_MEM_ARB_PERF_EN
      ,
      .perf_conflicts(perf_c[k]), .perf_if_wait(perf_iw[k]),
      .perf_d_wait(perf_dw[k])
`endif
    );
  end

  function automatic logic [31:0] rd_ext(input logic [31:0] w,
                                         input logic [1:0] sz,
                                         input logic u);
    case (sz)
      2'b01:   return u ? {24'b0, w[7:0]} : {{24{w[7]}}, w[7:0]};
      2'b10:   return u ? {16'b0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      2'b11:   return w;
      default: return 32'b0;
    endcase
  endfunction

  function automatic logic [31:0] wr_merge(input logic [31:0] old,
                                           input logic [31:0] wd,
                                           input logic [1:0] sz);
    case (sz)
      2'b01:   return {old[31:8], wd[7:0]};
      2'b10:   return {old[31:16], wd[15:0]};
      2'b11:   return wd;
      default: return old;
    endcase
  endfunction

  // Memory with MEM_LAT cycles of read latency, writes at the command edge.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      pipe[k][2] <= pipe[k][1];
      pipe[k][1] <= pipe[k][0];
      pipe[k][0] <= rd_ext(mem[k][m_addr[k]], m_read[k], m_uns[k]);
      if (m_write[k] != 2'b00)
        mem[k][m_addr[k]] <= wr_merge(mem[k][m_addr[k]], m_wdata[k], m_write[k]);
    end
    if (pl_we) mem[pl_k][pl_addr] <= pl_data;
  end

  assign m_rdata[0] = pipe[0][0];
  assign m_rdata[1] = pipe[1][2];

  function automatic logic [113:0] outs(input int k);
    return {if_gnt[k], if_rvalid[k], if_rdata[k], d_gnt[k], d_rvalid[k],
            d_rdata[k], m_addr[k], m_read[k], m_write[k], m_wdata[k],
            m_uns[k], m_fetch[k], stall_if[k], stall_mem[k]};
  endfunction

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 0; if_addr[k] = '0; d_req[k] = 0; d_re[k] = '0;
      d_we[k] = '0; d_uns[k] = 0; d_addr[k] = '0; d_wdata[k] = '0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic preload(input int k, input int a, input logic [31:0] d);
    pl_k = k; pl_addr = AW'(a); pl_data = d; pl_we = 1;
    @(negedge clk);
    pl_we = 0;
  endtask

  task automatic idle_cycles(input int n);
    clear_inputs();
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0;
    if_req[0] = 1; if_addr[0] = 6'd5; d_req[0] = 1; d_re[0] = 2'b11;
    if_req[1] = 1; d_req[1] = 1; d_we[1] = 2'b11; d_wdata[1] = 32'hFFFF_FFFF;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (outs(k) !== '0) begin
        errors++;
        $display("FAIL reset_outs k=%0d got=%h exp=0", k, outs(k));
      end
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_fetch();
    logic [2:0] exp_v [3];
    exp_v[0] = 3'b101; exp_v[1] = 3'b001; exp_v[2] = 3'b110;
    preload(0, 5, 32'h0050_0093);
    do_reset();
    if_req[0] = 1; if_addr[0] = 6'd5;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({if_gnt[0], if_rvalid[0], stall_if[0]} !== exp_v[c]) begin
        errors++;
        $display("FAIL fetch_hs cycle=%0d got=%b exp=%b", c + 1,
                 {if_gnt[0], if_rvalid[0], stall_if[0]}, exp_v[c]);
      end
      if (c == 0) begin
        checks++;
        if ({m_fetch[0], m_read[0], m_write[0], m_addr[0]} !== {1'b1, 2'b11, 2'b00, 6'd5}) begin
          errors++;
          $display("FAIL fetch_cmd got=%b exp=%b", {m_fetch[0], m_read[0], m_write[0], m_addr[0]},
                   {1'b1, 2'b11, 2'b00, 6'd5});
        end
      end
      if (c == 2) begin
        checks++;
        if (if_rdata[0] !== 32'h0050_0093) begin
          errors++;
          $display("FAIL fetch_rdata got=%h exp=00500093", if_rdata[0]);
        end
      end
      @(negedge clk);
    end
    idle_cycles(4);
  endtask

  task automatic test_streak();
    logic [1:0] eg;
    do_reset();
    if_req[0] = 1; if_addr[0] = 6'd1;
    d_req[0] = 1; d_re[0] = 2'b11; d_addr[0] = 6'd9;
    for (int c = 0; c < 10; c++) begin
      #1;
      eg = (c % 2 == 1) ? 2'b00 : (c == 6 ? 2'b10 : 2'b01);
      checks++;
      if ({if_gnt[0], d_gnt[0]} !== eg) begin
        errors++;
        $display("FAIL streak_order cycle=%0d got=%b exp=%b", c, {if_gnt[0], d_gnt[0]}, eg);
      end
      if (c == 6) begin
        checks++;
        if ({m_fetch[0], m_addr[0]} !== {1'b1, 6'd1}) begin
          errors++;
          $display("FAIL streak_fetch got=%b exp=%b", {m_fetch[0], m_addr[0]}, {1'b1, 6'd1});
        end
      end
      @(negedge clk);
    end
`ifdef UNIFIED_MEM_ARB_PERF_EN
    #1;
    checks++;
    if (perf_c[0] !== 32'd5) begin
      errors++;
      $display("FAIL perf_conflicts got=%0d exp=5", perf_c[0]);
    end
    checks++;
    if (perf_iw[0] < 32'd8) begin
      errors++;
      $display("FAIL perf_if_wait got=%0d exp>=8", perf_iw[0]);
    end
`endif
    idle_cycles(4);
  endtask

  task automatic test_store();
    do_reset();
    preload(0, 5, 32'h0050_0093);
    d_req[0] = 1; d_re[0] = 2'b11; d_addr[0] = 6'd5;
    #1;
    checks++;
    if (d_gnt[0] !== 1'b1) begin
      errors++;
      $display("FAIL load_gnt got=%b exp=1", d_gnt[0]);
    end
    @(negedge clk);
    d_req[0] = 0;
    @(negedge clk);
    #1;
    checks++;
    if ({d_rvalid[0], d_rdata[0]} !== {1'b1, 32'h0050_0093}) begin
      errors++;
      $display("FAIL load_resp got=%h exp=%h", {d_rvalid[0], d_rdata[0]}, {1'b1, 32'h0050_0093});
    end
    d_req[0] = 1; d_re[0] = 2'b11; d_we[0] = 2'b11;
    d_addr[0] = 6'd2; d_wdata[0] = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({d_gnt[0], m_read[0], m_write[0], m_addr[0], m_wdata[0]} !==
        {1'b1, 2'b00, 2'b11, 6'd2, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL store_cmd got=%h exp=%h",
               {d_gnt[0], m_read[0], m_write[0], m_addr[0], m_wdata[0]},
               {1'b1, 2'b00, 2'b11, 6'd2, 32'hDEAD_BEEF});
    end
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    #1;
    checks++;
    if ({d_rvalid[0], d_rdata[0]} !== {1'b1, 32'h0050_0093}) begin
      errors++;
      $display("FAIL store_resp got=%h exp=%h", {d_rvalid[0], d_rdata[0]}, {1'b1, 32'h0050_0093});
    end
    if_req[0] = 1; if_addr[0] = 6'd2;
    @(negedge clk);
    if_req[0] = 0;
    @(negedge clk);
    #1;
    checks++;
    if ({if_rvalid[0], if_rdata[0]} !== {1'b1, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL store_fetch got=%h exp=%h", {if_rvalid[0], if_rdata[0]}, {1'b1, 32'hDEAD_BEEF});
    end
    idle_cycles(3);
    d_req[0] = 1; d_addr[0] = 6'd4;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({d_gnt[0], stall_mem[0], m_read[0], m_write[0]} !== 6'b0) begin
        errors++;
        $display("FAIL null_dreq cycle=%0d got=%b exp=000000", c,
                 {d_gnt[0], stall_mem[0], m_read[0], m_write[0]});
      end
      @(negedge clk);
    end
    idle_cycles(2);
  endtask

  task automatic test_latency3();
    logic [2:0] got;
    do_reset();
    preload(1, 7, 32'h1234_5678);
    d_req[1] = 1; d_re[1] = 2'b11; d_addr[1] = 6'd7;
    for (int c = 0; c < 6; c++) begin
      #1;
      got = {d_gnt[1], d_rvalid[1], m_read[1] != 2'b00};
      checks++;
      if (got !== (c == 0 ? 3'b101 : (c == 4 ? 3'b010 : 3'b000))) begin
        errors++;
        $display("FAIL lat3 cycle=%0d got=%b exp=%b", c, got,
                 (c == 0 ? 3'b101 : (c == 4 ? 3'b010 : 3'b000)));
      end
      if (c == 4) begin
        checks++;
        if (d_rdata[1] !== 32'h1234_5678) begin
          errors++;
          $display("FAIL lat3_rdata got=%h exp=12345678", d_rdata[1]);
        end
      end
      @(negedge clk);
      d_req[1] = 0;
    end
    idle_cycles(2);
  endtask

  task automatic test_reset_wait();
    do_reset();
    d_req[1] = 1; d_re[1] = 2'b11; d_addr[1] = 6'd7;
    #1;
    checks++;
    if (d_gnt[1] !== 1'b1) begin
      errors++;
      $display("FAIL rw_gnt got=%b exp=1", d_gnt[1]);
    end
    @(negedge clk);
    #1;
    rst_n = 0;
    #1;
    checks++;
    if (outs(1) !== '0) begin
      errors++;
      $display("FAIL rw_outs got=%h exp=0", outs(1));
    end
    d_req[1] = 0;
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if ({if_rvalid[1], d_rvalid[1], if_gnt[1], d_gnt[1]} !== 4'b0) begin
        errors++;
        $display("FAIL rw_quiet cycle=%0d got=%b exp=0000", c,
                 {if_rvalid[1], d_rvalid[1], if_gnt[1], d_gnt[1]});
      end
      @(negedge clk);
    end
    if_req[1] = 1; if_addr[1] = 6'd3;
    #1;
    checks++;
    if (if_gnt[1] !== 1'b1) begin
      errors++;
      $display("FAIL rw_regrant got=%b exp=1", if_gnt[1]);
    end
    @(negedge clk);
    idle_cycles(6);
  endtask

  task automatic test_random(input int k, input int n);
    logic [31:0] ref_mem [64];
    int lat, cyc, free_at, done_at, streak;
    bit ip, dp, d_eff, g, win, rv_i, rv_d, done_if, done_st;
    logic [AW-1:0] ia, da;
    logic [1:0] dre, dwe, e_rd, e_wr;
    logic du;
    logic [31:0] dw, done_data, e_ird, e_drd;
    lat = (k == 0) ? 1 : 3;
    do_reset();
    for (int a = 0; a < 64; a++) ref_mem[a] = mem[k][a];
    cyc = 0; free_at = 0; done_at = -1; streak = 0;
    ip = 0; dp = 0; done_if = 0; done_st = 0; done_data = '0;
    e_ird = '0; e_drd = '0;
    ia = '0; da = '0; dre = '0; dwe = '0; du = 0; dw = '0;
    repeat (n) begin
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip = 1; ia = AW'($urandom_range(0, 15));
      end
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp = 1; dre = 2'($urandom_range(0, 3)); du = 1'($urandom_range(0, 1));
        dwe = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
        da = AW'($urandom_range(0, 15)); dw = $urandom;
      end
      if_req[k] = ip; if_addr[k] = ia;
      d_req[k] = dp; d_re[k] = dre; d_we[k] = dwe; d_uns[k] = du;
      d_addr[k] = da; d_wdata[k] = dw;
      #1;
      d_eff = dp && (dre != 2'b00 || dwe != 2'b00);
      rv_i = (cyc == done_at) && done_if;
      rv_d = (cyc == done_at) && !done_if;
      if (rv_i) e_ird = done_data;
      if (rv_d && !done_st) e_drd = done_data;
      g = (cyc >= free_at) && (ip || d_eff);
      win = ip && (!d_eff || streak == 3);
      checks++;
      if ({if_gnt[k], d_gnt[k], if_rvalid[k], d_rvalid[k], stall_if[k], stall_mem[k]} !==
          {g && win, g && !win, rv_i, rv_d, ip && !rv_i, d_eff && !rv_d}) begin
        errors++;
        $display("FAIL rnd_hs k=%0d cyc=%0d got=%b exp=%b", k, cyc,
                 {if_gnt[k], d_gnt[k], if_rvalid[k], d_rvalid[k], stall_if[k], stall_mem[k]},
                 {g && win, g && !win, rv_i, rv_d, ip && !rv_i, d_eff && !rv_d});
      end
      checks++;
      if ({if_rdata[k], d_rdata[k]} !== {e_ird, e_drd}) begin
        errors++;
        $display("FAIL rnd_rdata k=%0d cyc=%0d got=%h exp=%h", k, cyc,
                 {if_rdata[k], d_rdata[k]}, {e_ird, e_drd});
      end
      e_rd = !g ? 2'b00 : (win ? 2'b11 : (dwe != 2'b00 ? 2'b00 : dre));
      e_wr = (g && !win) ? dwe : 2'b00;
      checks++;
      if ({m_read[k], m_write[k]} !== {e_rd, e_wr}) begin
        errors++;
        $display("FAIL rnd_cmd k=%0d cyc=%0d got=%b exp=%b", k, cyc,
                 {m_read[k], m_write[k]}, {e_rd, e_wr});
      end
      if (g) begin
        checks++;
        if ({m_addr[k], m_fetch[k]} !== {win ? ia : da, win}) begin
          errors++;
          $display("FAIL rnd_addr k=%0d cyc=%0d got=%b exp=%b", k, cyc,
                   {m_addr[k], m_fetch[k]}, {win ? ia : da, win});
        end
      end
      if (g && !win) begin
        checks++;
        if ({m_uns[k], (dwe != 2'b00) ? m_wdata[k] : 32'b0} !== {du, (dwe != 2'b00) ? dw : 32'b0}) begin
          errors++;
          $display("FAIL rnd_dcmd k=%0d cyc=%0d got=%h exp=%h", k, cyc,
                   {m_uns[k], m_wdata[k]}, {du, dw});
        end
      end
      if (g) begin
        free_at = cyc + lat + 1;
        done_at = free_at;
        done_if = win;
        done_st = !win && dwe != 2'b00;
        if (win)
          done_data = ref_mem[ia];
        else if (dwe != 2'b00)
          ref_mem[da] = wr_merge(ref_mem[da], dw, dwe);
        else
          done_data = rd_ext(ref_mem[da], dre, du);
      end
      if (!ip || (g && win)) streak = 0;
      else if (g && streak < 3) streak++;
      if (g && win) ip = 0;
      if ((g && !win) || !d_eff) dp = 0;
      cyc++;
      @(negedge clk);
    end
    idle_cycles(6);
  endtask

  initial begin
    rst_n = 0;
    pl_we = 0; pl_k = 0; pl_addr = '0; pl_data = '0;
    clear_inputs();
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 64; a++)
        preload(k, a, $urandom);
    test_reset();
    test_fetch();
    test_streak();
    test_store();
    test_latency3();
    test_reset_wait();
    test_random(0, 400);
    test_random(1, 400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
